// File: rtl/table_rmw_ctrl_if.sv
// Client and table-macro signals of table_rmw_ctrl, bundled with modports.
// The controller uses the slave view; the master view drives requests and models the table.
interface table_rmw_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_inc;
  logic              init_done;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic              mem_R0_en;
  logic [DATA_W-1:0] mem_R0_data;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic              mem_W0_en;
  logic [DATA_W-1:0] mem_W0_data;

  modport slave (
    input  req_valid, req_addr, upd_valid, upd_addr, upd_inc, mem_R0_data,
    output req_ready, resp_valid, resp_data, upd_ready, init_done,
           mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data
  );

  modport master (
    output req_valid, req_addr, upd_valid, upd_addr, upd_inc, mem_R0_data,
    input  req_ready, resp_valid, resp_data, upd_ready, init_done,
           mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data
  );
endinterface

// File: rtl/table_rmw_ctrl.sv
// Clear-then-serve controller for a 1R1W table of saturating counters with lookup and RMW update.
// Optional macro TABLE_RMW_STATS_EN adds a saturated-update counter (sat_count) with clear (stats_clr).
module table_rmw_ctrl #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DATA_W   = 12,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  table_rmw_ctrl_if.slave   bus
`ifdef TABLE_RMW_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       sat_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [DATA_W-1:0] MAX_VAL  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_idx;

  logic              r_s1_valid;
  logic              r_s1_upd;
  logic              r_s1_inc;
  logic [ADDR_W-1:0] r_s1_addr;

  logic              r_fwd_valid;
  logic [ADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0] r_fwd_data;

  logic              w_req_acc;
  logic              w_upd_acc;
  logic              w_upd_wr;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_new;

  // The macro's read is undefined when it collides with a write, so the last write is replayed.
  assign w_rd_val = (r_fwd_valid && (r_fwd_addr == r_s1_addr)) ? r_fwd_data : bus.mem_R0_data;
  assign w_upd_wr = r_s1_valid && r_s1_upd;
  assign w_new    = r_s1_inc ? ((w_rd_val == MAX_VAL) ? w_rd_val : w_rd_val + 1'b1)
                             : ((w_rd_val == '0)      ? w_rd_val : w_rd_val - 1'b1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_INIT) r_idx <= r_idx + 1'b1;
    end
  end

  // Outputs are gated by reset_n so the table sees no writes while reset is held.
  always_comb begin
    w_next_state    = r_state;
    w_req_acc       = 1'b0;
    w_upd_acc       = 1'b0;
    bus.req_ready   = 1'b0;
    bus.upd_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = '0;
    bus.init_done   = 1'b0;
    bus.mem_R0_en   = 1'b0;
    bus.mem_R0_addr = '0;
    bus.mem_W0_en   = 1'b0;
    bus.mem_W0_addr = '0;
    bus.mem_W0_data = '0;
    if ((r_state == ST_INIT) && (r_idx == LAST_IDX)) w_next_state = ST_RUN;
    if (reset_n) begin
      case (r_state)
        ST_INIT: begin
          bus.mem_W0_en   = 1'b1;
          bus.mem_W0_addr = r_idx;
          bus.mem_W0_data = INIT_VAL;
        end
        ST_RUN: begin
          bus.init_done = 1'b1;
          bus.req_ready = 1'b1;
          bus.upd_ready = !bus.req_valid;
          w_req_acc     = bus.req_valid;
          w_upd_acc     = bus.upd_valid && !bus.req_valid;
          if (w_req_acc) begin
            bus.mem_R0_en   = 1'b1;
            bus.mem_R0_addr = bus.req_addr;
          end else if (w_upd_acc) begin
            bus.mem_R0_en   = 1'b1;
            bus.mem_R0_addr = bus.upd_addr;
          end
          if (r_s1_valid && !r_s1_upd) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = w_rd_val;
          end
          if (w_upd_wr) begin
            bus.mem_W0_en   = 1'b1;
            bus.mem_W0_addr = r_s1_addr;
            bus.mem_W0_data = w_new;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_upd   <= 1'b0;
      r_s1_inc   <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= w_req_acc || w_upd_acc;
      r_s1_upd   <= w_upd_acc;
      r_s1_inc   <= bus.upd_inc;
      r_s1_addr  <= w_req_acc ? bus.req_addr : bus.upd_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= (r_state == ST_RUN) && w_upd_wr;
      if ((r_state == ST_RUN) && w_upd_wr) begin
        r_fwd_addr <= r_s1_addr;
        r_fwd_data <= w_new;
      end
    end
  end

`ifdef TABLE_RMW_STATS_EN
  logic [15:0] r_sat_count;
  logic        w_sat_hit;

  assign w_sat_hit = (r_state == ST_RUN) && w_upd_wr &&
                     (r_s1_inc ? (w_rd_val == MAX_VAL) : (w_rd_val == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_count <= '0;
    end else if (stats_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_hit && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule

// File: doc/table_rmw_ctrl.md
Name: table_rmw_ctrl

Overview:
Controller that drives the read and write ports of a 1R1W synchronous table macro of 256 entries x 12 bits. The macro has 1-cycle registered-address read latency and its data is undefined when the read enable was low.
- Clears the table after reset.
- Serves client lookups.
- Performs saturating-counter read-modify-write updates, with forwarding to cover the macro's undefined same-address read-during-write.
- Sits between predictor/statistics logic and the table instance; the table's R0_clk and W0_clk tie to the same clock.

Parameters:
ADDR_W, 8, table address width; depth = 2**ADDR_W
DATA_W, 12, entry width; each entry is an unsigned saturating counter
INIT_VAL, 0, value written to every entry during the init sweep

Ports:
clock  in  1  single clock for controller and table
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  lookup request
req_ready  out  1  lookup accepted when req_valid & req_ready
req_addr  in  ADDR_W  lookup address
resp_valid  out  1  lookup data valid; no backpressure
resp_data  out  DATA_W  lookup result
upd_valid  in  1  update request
upd_ready  out  1  update accepted when upd_valid & upd_ready
upd_addr  in  ADDR_W  update address
upd_inc  in  1  1 = +1 saturate at 2**DATA_W-1; 0 = -1 saturate at 0
init_done  out  1  high once the clear sweep has finished
mem_R0_addr  out  ADDR_W  to table R0_addr
mem_R0_en  out  1  to table R0_en
mem_R0_data  in  DATA_W  from table R0_data
mem_W0_addr  out  ADDR_W  to table W0_addr
mem_W0_en  out  1  to table W0_en
mem_W0_data  out  DATA_W  to table W0_data

Behaviour:
- Reset (async assert, sync release): every output is 0 and all pipeline, forward and stat registers clear. The FSM enters INIT with index 0.
- INIT state:
  - Each cycle drives mem_W0_en=1, mem_W0_addr=index, mem_W0_data=INIT_VAL, then index++.
  - After the write to index 2**ADDR_W-1, go to RUN: 256 cycles for the default depth.
  - req_ready, upd_ready and init_done are 0 in INIT; requests are ignored.
  - Reset asserted mid-sweep restarts the sweep at index 0.
- RUN state: init_done=1. There is a single read port, and a lookup has priority over an update.
  - req_ready=1 always.
  - upd_ready = !req_valid.
- Read issue:
  - On an accepted lookup or accepted update, drive mem_R0_en=1 and mem_R0_addr = the request address combinationally in the accept cycle t.
  - Register the op type and address into stage S1.
- Stage S1, cycle t+1, lookup: resp_valid=1 and resp_data = the read value. Lookup latency is exactly 1 cycle.
- Stage S1, cycle t+1, update:
  - new = sat(read value ± 1).
  - Drive mem_W0_en=1, mem_W0_addr=S1 addr, mem_W0_data=new in that same cycle.
  - The table holds the new value from the cycle-t+1 edge onward. Update throughput is 1 per cycle.
- Forwarding:
  - Whenever mem_W0_en is high in RUN, capture {fwd_valid=1, fwd_addr, fwd_data} at the edge; otherwise fwd_valid=0.
  - The "read value" in S1 is fwd_data if fwd_valid && fwd_addr == S1 addr, else mem_R0_data.
  - This covers a read issued in the same cycle as a write to the same address. Back-to-back updates to one address must accumulate without loss.
- Arithmetic: DATA_W-bit unsigned. Increment at all-ones holds; decrement at 0 holds; no wrap.
- Simultaneous req_valid and upd_valid: the lookup is served and upd_ready=0. The update must hold upd_valid until it is accepted.

Optional Feature:
TABLE_RMW_STATS_EN
- Defined: adds output sat_count[15:0] and input stats_clr.
  - sat_count increments on each S1 update whose operand was already saturated (inc at max, or dec at 0).
  - It saturates at 16'hFFFF.
  - It clears on reset or on stats_clr; stats_clr wins over a simultaneous increment.
- Not defined: neither port exists, and there is no counting logic.

Test Plan:
- Release reset -> mem_W0_en high for exactly 256 cycles with addresses 0..255 and data 0; then init_done=1. A lookup of addr 0x5A returns resp_data=0 one cycle after accept.
- 3 updates, addr 0x10, inc=1, on consecutive cycles -> lookup 0x10 returns 3. This proves forwarding across back-to-back same-address RMW.
- Update addr 0x20 inc=0 with the entry at 0 -> entry stays 0. With STATS_EN, sat_count=1.
- Preload 0x30 to 0xFFF via 4095 inc updates, then one more inc -> lookup returns 0xFFF.
- req_valid and upd_valid high in the same cycle -> upd_ready=0, the lookup response arrives next cycle, and the update is accepted the following cycle.
- Assert reset_n=0 at sweep index 100 -> all outputs go to 0 immediately. After release, the sweep restarts at index 0 and runs for 256 cycles.
